// File: rtl/lsu_mem_port_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the LSU itself, master = the pipeline stage plus data memory.
interface lsu_mem_port_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rd_data;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wr_data, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wr_data, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: word-only memory, read-modify-write for sub-word stores.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two word accesses.
module lsu_mem_port #(
    parameter int unsigned ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_RSP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            r_state, w_next;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_w0, r_w1, r_rdata;
    logic              r_err;

    logic              w_req_bad, w_req_sw_al, w_cross;
    logic [1:0]        w_off;
    logic [3:0]        w_size_mask;
    logic [7:0]        w_st_mask;
    logic [63:0]       w_st_stream;
    logic [ADDR_W-1:0] w_a0, w_a1;
    logic [31:0]       w_w0, w_w1, w_ld_raw, w_ld_ext, w_wr0, w_wr1;

    // Classify the incoming request; only steers the IDLE transition
    always_comb begin
        w_req_bad = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: w_req_bad = 1'b0;
            F3_BU, F3_HU:     w_req_bad = bus.req_write;
            default:          w_req_bad = 1'b1;
        endcase
`ifndef LSU_MISALIGN_EN
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            w_req_bad = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            w_req_bad = 1'b1;
`endif
    end

    assign w_req_sw_al = bus.req_write && (bus.req_funct3 == F3_W) && (bus.req_addr[1:0] == 2'b00);

    assign w_off = r_addr[1:0];
    assign w_a0  = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_a1  = w_a0 + ADDR_W'(4);

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    logic [2:0] w_size;
    assign w_size  = (r_funct3[1:0] == 2'b00) ? 3'd1 : (r_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_cross = (3'(w_off) + w_size) > 3'd4;
`else
    assign w_cross = 1'b0;
`endif

    // Load path: the word being read this cycle is used before it lands in r_w0/r_w1
    assign w_w0     = (r_state == S_RD0) ? bus.mem_rd_data : r_w0;
    assign w_w1     = (r_state == S_RD1) ? bus.mem_rd_data : r_w1;
    assign w_ld_raw = 32'({w_w1, w_w0} >> {w_off, 3'b000});

    always_comb begin
        case (r_funct3)
            F3_B:    w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            F3_H:    w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            F3_BU:   w_ld_ext = {24'h0, w_ld_raw[7:0]};
            F3_HU:   w_ld_ext = {16'h0, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    // Store merge: bytes 0..3 of the shifted stream land in A0, bytes 4..7 in A1
    assign w_st_stream = 64'(r_wdata) << {w_off, 3'b000};
    assign w_st_mask   = 8'(w_size_mask) << w_off;

    always_comb begin
        w_wr0 = r_w0;
        w_wr1 = r_w1;
        for (int i = 0; i < 4; i++) begin
            if (w_st_mask[i])
                w_wr0[8*i +: 8] = w_st_stream[8*i +: 8];
            if (w_st_mask[4+i])
                w_wr1[8*i +: 8] = w_st_stream[32+8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and memory strobes; everything is forced quiet while rst is high
    always_comb begin
        w_next          = r_state;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = 32'h0;
        bus.resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_bad)        w_next = S_RSP;
                    else if (w_req_sw_al) w_next = S_WR0;
                    else                  w_next = S_RD0;
                end
            end
            S_RD0: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = w_a0;
                if (w_cross)      w_next = S_RD1;
                else if (r_write) w_next = S_WR0;
                else              w_next = S_RSP;
            end
            S_RD1: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = w_a1;
                w_next       = r_write ? S_WR0 : S_RSP;
            end
            S_WR0: begin
                bus.mem_write   = 1'b1;
                bus.mem_addr    = w_a0;
                bus.mem_wr_data = w_wr0;
                w_next          = w_cross ? S_WR1 : S_RSP;
            end
            S_WR1: begin
                bus.mem_write   = 1'b1;
                bus.mem_addr    = w_a1;
                bus.mem_wr_data = w_wr1;
                w_next          = S_RSP;
            end
            S_RSP: begin
                bus.resp_valid = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.mem_addr    = '0;
            bus.mem_wr_data = 32'h0;
            bus.resp_valid  = 1'b0;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) || rst;
    assign bus.resp_rdata = rst ? 32'h0 : r_rdata;
    assign bus.resp_err   = rst ? 1'b0 : r_err;

    // Request latch, read-word capture and held response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_w0     <= 32'h0;
            r_w1     <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.req_valid) begin
                r_write  <= bus.req_write;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (r_state == S_RD0) r_w0 <= bus.mem_rd_data;
            if (r_state == S_RD1) r_w1 <= bus.mem_rd_data;
            if (w_next == S_RSP) begin
                r_err   <= (r_state == S_IDLE);
                r_rdata <= (!r_write && (r_state == S_RD0 || r_state == S_RD1)) ? w_ld_ext : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed cases then random requests against a byte-level model.
module tb_lsu_mem_port;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_mem_port #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Word memory seen by the DUT (256 bytes, address taken modulo 256)
    logic [31:0] mem [64];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;

    assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus.mem_write) begin
            wr_cnt <= wr_cnt + 1;
            mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
        end
        if (pl_we) mem[pl_idx] <= pl_data;
    end

    // Reference byte memory
    logic [7:0] ref_mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if ((f3 == 3'd4 || f3 == 3'd5) && w) return 1'b1;
`ifndef LSU_MISALIGN_EN
        if (size_of(f3) == 2 && a[0]) return 1'b1;
        if (size_of(f3) == 4 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int          n;
        v = 32'h0;
        n = size_of(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[8'({a[7:2], 2'b00}) + 8'(i)];
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input int limit);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n && i < limit; i++) ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[8'({a[7:2], 2'b00}) + 8'(i)] = d[8*i +: 8];
    endtask

    task automatic drive_junk();
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_write  = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    // One full transaction: drive, wait for the pulse, compare against the model
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int unsigned rd0, wr0;
        int          cyc, exp_cyc, exp_rd, exp_wr;
        bit          err, cr, swal;
        logic [31:0] exp_data;
        err  = is_err(w, f3, a);
        cr   = !err && (int'(a[1:0]) + size_of(f3) > 4);
        swal = !err && w && f3 == 3'd2 && a[1:0] == 2'b00;
        exp_cyc  = err ? 1 : w ? (swal ? 2 : (cr ? 5 : 3)) : (cr ? 3 : 2);
        exp_rd   = (err || swal) ? 0 : (cr ? 2 : 1);
        exp_wr   = (err || !w) ? 0 : (cr ? 2 : 1);
        exp_data = (err || w) ? 32'h0 : ref_load(f3, a);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = d;
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc < 8) begin
            if (bus.mem_read || bus.mem_write)
                check({tag, " align"}, 32'(bus.mem_addr[1:0]), 32'd0);
            drive_junk();
            @(posedge clk); #1;
            cyc++;
        end
        bus.req_valid = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " rdata"}, bus.resp_rdata, exp_data);
        check({tag, " err"}, 32'(bus.resp_err), 32'(err));
        check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (!err && w) begin
            ref_store(f3, a, d, 4);
            check({tag, " word A0"}, mem[a[7:2]], ref_word(a));
            check({tag, " word A1"}, mem[a[7:2] + 6'd1], ref_word(a + 32'd4));
        end
        @(posedge clk); #1;
        check({tag, " pulse end"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rd;
        logic [2:0]  rf3;
        logic        rw;
        int          rst_cyc, first_lim;
        int unsigned wr0;

        rst = 1'b1; pl_we = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        @(posedge clk); @(negedge clk);
        check("rst ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst mem_write", 32'(bus.mem_write), 32'd0);
        check("rst mem_read", 32'(bus.mem_read), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wr_data", bus.mem_wr_data, 32'h0);
        check("rst rdata", bus.resp_rdata, 32'h0);
        check("rst err", 32'(bus.resp_err), 32'd0);
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        @(negedge clk);
        rst = 1'b0;

        preload(32'h10, 32'h11223344);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw");
        check("lw const", bus.resp_rdata, 32'h11223344);

        preload(32'h10, 32'h80FF0000);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, "lb");
        check("lb const", bus.resp_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, "lbu");
        check("lbu const", bus.resp_rdata, 32'h00000080);

        preload(32'h20, 32'h44332211);
        do_req(1'b1, 3'd0, 32'h21, 32'h000000AB, "sb");
        check("sb const", mem[8], 32'h4433AB11);

`ifdef LSU_MISALIGN_EN
        preload(32'h2C, 32'h0);
        preload(32'h30, 32'h0);
        do_req(1'b1, 3'd2, 32'h2E, 32'hDDCCBBAA, "sw cross");
        check("sw cross A0", mem[11], 32'hBBAA0000);
        check("sw cross A1", mem[12], 32'h0000DDCC);
        preload(32'hFFFFFFFC, 32'h5566ABCD);
        preload(32'h0, 32'h12347788);
        do_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, "lw wrap");
        check("lw wrap const", bus.resp_rdata, 32'h77885566);
        ra = 32'h36; rst_cyc = 4; first_lim = 2;
`else
        do_req(1'b0, 3'd1, 32'h41, 32'h0, "lh misaligned");
        check("lh misaligned err", 32'(bus.resp_err), 32'd1);
        preload(32'hFFFFFFFC, 32'h5566ABCD);
        do_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, "lw wrap");
        do_req(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, "lw top");
        check("lw top const", bus.resp_rdata, 32'h5566ABCD);
        ra = 32'h45; rst_cyc = 2; first_lim = 0;
`endif
        do_req(1'b0, 3'd3, 32'h40, 32'h0, "f3 011");
        check("f3 011 err", 32'(bus.resp_err), 32'd1);

        // Reset during the last write strobe of a store
        rf3 = (first_lim == 0) ? 3'd0 : 3'd2;
        rd  = 32'hDDCCBBAA;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = rf3;
        bus.req_addr = ra; bus.req_wdata = rd;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (rst_cyc - 1) begin @(posedge clk); #1; end
        check("midrst strobe before", 32'(bus.mem_write), 32'd1);
        rst = 1'b1; #1;
        check("midrst strobe forced", 32'(bus.mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_store(rf3, ra, rd, first_lim);
        check("midrst writes", 32'(wr_cnt - wr0), 32'(first_lim == 0 ? 0 : 1));
        check("midrst A0", mem[ra[7:2]], ref_word(ra));
        check("midrst A1", mem[ra[7:2] + 6'd1], ref_word(ra + 32'd4));
        check("midrst ready", 32'(bus.req_ready), 32'd1);
        check("midrst rdata", bus.resp_rdata, 32'h0);
        do_req(1'b0, 3'd2, 32'h80, 32'h0, "after midrst");

        for (int n = 0; n < 250; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255)))
                                              : 32'($urandom_range(0, 255));
            rd  = $urandom;
            do_req(rw, rf3, ra, rd, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
